// File: rtl/ahb_slave_itfc_gen.sv
// AHB slave interface for an AHB-to-APB bridge: one-hot region decode, a
// two-cycle ERROR response FSM and a PIPE_DEPTH-stage address/data/direction pipeline.
module ahb_slave_itfc_gen #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_SLAVES  = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0] REGION_SIZE = ADDR_W'(32'h0400_0000),
    parameter int unsigned       PIPE_DEPTH  = 2
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  Hwrite,
    input  logic                  Hreadyin,
    input  logic [1:0]            Htrans,
    input  logic [ADDR_W-1:0]     Haddr,
    input  logic [DATA_W-1:0]     Hwdata,
    input  logic                  stall_in,
    output logic                  Hreadyout,
    output logic [1:0]            Hresp,
    output logic [ADDR_W-1:0]     Haddr_p,
    output logic [DATA_W-1:0]     Hwdata_p,
    output logic                  Hwritereg,
    output logic [NUM_SLAVES-1:0] tempselx,
    output logic                  valid
);

    // Extra headroom so BASE_ADDR + NUM_SLAVES*REGION_SIZE never wraps.
    localparam int unsigned       EXT_W   = ADDR_W + 4;
    localparam int unsigned       RS_LOG2 = $clog2(REGION_SIZE);
    localparam logic [EXT_W-1:0]  SPAN    = EXT_W'(NUM_SLAVES) * EXT_W'(REGION_SIZE);

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              write;
    } stage_t;

    state_e state_q, state_d;
    stage_t [PIPE_DEPTH-1:0] pipe_q, pipe_d;

    logic [EXT_W-1:0] offset;
    logic [EXT_W-1:0] region_idx;
    logic             mapped;
    logic             active;
    logic             is_idle;
    logic             err_start;
    logic             shift;

    // Region decode; the index is only formed once the address is known to be in range.
    always_comb begin
        offset     = EXT_W'(Haddr) - EXT_W'(BASE_ADDR);
        mapped     = (Haddr >= BASE_ADDR) && (offset < SPAN);
        region_idx = mapped ? (offset >> RS_LOG2) : '0;
        tempselx   = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            tempselx[i] = mapped && (region_idx == EXT_W'(i));
        end
    end

    // Transfer qualification; an active unmapped transfer starts an error and never shifts.
    always_comb begin
        active    = Hreadyin && ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));
        is_idle   = (state_q == ST_IDLE);
        err_start = is_idle && active && !mapped;
        shift     = is_idle && Hreadyin && !stall_in && !err_start;
        valid     = is_idle && active && mapped && !stall_in;
    end

    // Response FSM next state and outputs.
    always_comb begin
        state_d   = state_q;
        Hresp     = HRESP_OKAY;
        Hreadyout = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                Hreadyout = !stall_in;
                if (err_start) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                Hresp     = HRESP_ERROR;
                Hreadyout = 1'b0;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                Hresp     = HRESP_ERROR;
                Hreadyout = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pipeline next state: all stages move together or all hold.
    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_pipe
        if (g == 0) begin : g_head
            assign pipe_d[g] = shift ? stage_t'{addr: Haddr, data: Hwdata, write: Hwrite}
                                     : pipe_q[g];
        end else begin : g_tail
            assign pipe_d[g] = shift ? pipe_q[g-1] : pipe_q[g];
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= ST_IDLE;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            pipe_q  <= pipe_d;
        end
    end

    assign Haddr_p   = pipe_q[PIPE_DEPTH-1].addr;
    assign Hwdata_p  = pipe_q[PIPE_DEPTH-1].data;
    assign Hwritereg = pipe_q[PIPE_DEPTH-1].write;

endmodule

// File: tb/tb_ahb_slave_itfc_gen.sv
// Directed bench for ahb_slave_itfc_gen: default instance plus an 8-region,
// 4-stage instance sharing the same AHB stimulus.
module tb_ahb_slave_itfc_gen;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        Hclk;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        stall_in;

    logic        hreadyout0, hwritereg0, valid0;
    logic [1:0]  hresp0;
    logic [31:0] haddr_p0, hwdata_p0;
    logic [2:0]  tempselx0;

    logic        hreadyout1, hwritereg1, valid1;
    logic [1:0]  hresp1;
    logic [31:0] haddr_p1, hwdata_p1;
    logic [7:0]  tempselx1;

    int n_checks = 0;
    int n_errors = 0;

    ahb_slave_itfc_gen u_dut0 (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .stall_in  (stall_in),
        .Hreadyout (hreadyout0),
        .Hresp     (hresp0),
        .Haddr_p   (haddr_p0),
        .Hwdata_p  (hwdata_p0),
        .Hwritereg (hwritereg0),
        .tempselx  (tempselx0),
        .valid     (valid0)
    );

    ahb_slave_itfc_gen #(
        .NUM_SLAVES (8),
        .PIPE_DEPTH (4)
    ) u_dut1 (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .stall_in  (stall_in),
        .Hreadyout (hreadyout1),
        .Hresp     (hresp1),
        .Haddr_p   (haddr_p1),
        .Hwdata_p  (hwdata_p1),
        .Hwritereg (hwritereg1),
        .tempselx  (tempselx1),
        .valid     (valid1)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of AHB inputs on the falling edge, settle, then return.
    task automatic drive(input logic [1:0] trans, input logic write, input logic [31:0] addr,
                         input logic [31:0] data, input logic rdy, input logic stall);
        @(negedge Hclk);
        Htrans   = trans;
        Hwrite   = write;
        Haddr    = addr;
        Hwdata   = data;
        Hreadyin = rdy;
        stall_in = stall;
        #1;
    endtask

    task automatic tick;
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        Hresetn  = 1'b0;
        Htrans   = T_IDLE;
        Hwrite   = 1'b0;
        Haddr    = '0;
        Hwdata   = '0;
        Hreadyin = 1'b0;
        stall_in = 1'b1;
        #2;
        check_eq("rst_hreadyout_stall", hreadyout0, 1'b0);
        check_eq("rst_hresp",           hresp0, 2'b00);
        check_eq("rst_haddr_p",         haddr_p0, 32'h0);
        check_eq("rst_hwdata_p",        hwdata_p0, 32'h0);
        check_eq("rst_hwritereg",       hwritereg0, 1'b0);
        stall_in = 1'b0;
        #1;
        check_eq("rst_hreadyout",       hreadyout0, 1'b1);
        @(negedge Hclk);
        Hresetn = 1'b1;

        // Mapped NONSEQ write, two-stage latency
        drive(T_NONSEQ, 1'b1, 32'h8400_0010, 32'hA5A5_A5A5, 1'b1, 1'b0);
        check_eq("wr_tempselx", tempselx0, 3'b010);
        check_eq("wr_valid",    valid0, 1'b1);
        tick;
        check_eq("wr_lat1_haddr_p", haddr_p0, 32'h0);
        drive(T_IDLE, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        tick;
        check_eq("wr_lat2_haddr_p",   haddr_p0, 32'h8400_0010);
        check_eq("wr_lat2_hwritereg", hwritereg0, 1'b1);
        check_eq("wr_lat2_hwdata_p",  hwdata_p0, 32'hA5A5_A5A5);
        drive(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;

        // Unmapped NONSEQ: two-cycle error, pipeline frozen
        drive(T_NONSEQ, 1'b0, 32'h9000_0000, 32'h1234, 1'b1, 1'b0);
        check_eq("err_tempselx",  tempselx0, 3'b000);
        check_eq("err_valid",     valid0, 1'b0);
        check_eq("err_pre_hresp", hresp0, 2'b00);
        tick;
        check_eq("err1_hresp",     hresp0, 2'b01);
        check_eq("err1_hreadyout", hreadyout0, 1'b0);
        check_eq("err1_haddr_p",   haddr_p0, 32'h8400_0010);
        drive(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        check_eq("err1_stall_ignored", hreadyout0, 1'b0);
        tick;
        check_eq("err2_hresp",     hresp0, 2'b01);
        check_eq("err2_hreadyout", hreadyout0, 1'b1);
        check_eq("err2_haddr_p",   haddr_p0, 32'h8400_0010);
        drive(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        check_eq("err_done_hresp",     hresp0, 2'b00);
        check_eq("err_done_hreadyout", hreadyout0, 1'b1);
        check_eq("err_done_haddr_p",   haddr_p0, 32'h8400_0010);
        check_eq("err_done_hwritereg", hwritereg0, 1'b1);

        // SEQ burst with three stalled cycles
        drive(T_NONSEQ, 1'b1, 32'h8800_0000, 32'h1111_0000, 1'b1, 1'b0);
        check_eq("burst_tempselx", tempselx0, 3'b100);
        check_eq("burst_valid0",   valid0, 1'b1);
        tick;
        check_eq("burst_haddr_p0", haddr_p0, 32'h8000_0000);
        for (int k = 0; k < 3; k++) begin
            drive(T_SEQ, 1'b1, 32'h8800_0004, 32'h1111_0004, 1'b1, 1'b1);
            check_eq("stall_hreadyout", hreadyout0, 1'b0);
            check_eq("stall_valid",     valid0, 1'b0);
            tick;
            check_eq("stall_haddr_p",   haddr_p0, 32'h8000_0000);
        end
        drive(T_SEQ, 1'b1, 32'h8800_0004, 32'h1111_0004, 1'b1, 1'b0);
        check_eq("resume_valid",     valid0, 1'b1);
        check_eq("resume_hreadyout", hreadyout0, 1'b1);
        tick;
        check_eq("resume_haddr_p",  haddr_p0, 32'h8800_0000);
        check_eq("resume_hwdata_p", hwdata_p0, 32'h1111_0000);
        drive(T_SEQ, 1'b1, 32'h8800_0008, 32'h1111_0008, 1'b1, 1'b0);
        tick;
        check_eq("resume2_haddr_p",  haddr_p0, 32'h8800_0004);
        check_eq("resume2_hwdata_p", hwdata_p0, 32'h1111_0004);
        drive(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;

        // BUSY to an unmapped address is not a transfer
        drive(T_BUSY, 1'b0, 32'h9000_0000, 32'h0, 1'b1, 1'b0);
        check_eq("busy_valid",    valid0, 1'b0);
        check_eq("busy_tempselx", tempselx0, 3'b000);
        tick;
        check_eq("busy_hresp",     hresp0, 2'b00);
        check_eq("busy_hreadyout", hreadyout0, 1'b1);

        // Decode boundaries with Hreadyin low
        drive(T_NONSEQ, 1'b0, 32'h7FFF_FFFC, 32'h0, 1'b0, 1'b0);
        check_eq("below_base_tempselx", tempselx0, 3'b000);
        check_eq("notready_valid",      valid0, 1'b0);
        tick;
        check_eq("notready_hresp",      hresp0, 2'b00);
        drive(T_NONSEQ, 1'b0, 32'h8BFF_FFFF, 32'h0, 1'b0, 1'b0);
        check_eq("top_r2_tempselx0", tempselx0, 3'b100);
        check_eq("top_r2_tempselx1", tempselx1, 8'h04);
        drive(T_NONSEQ, 1'b0, 32'h8C00_0000, 32'h0, 1'b0, 1'b0);
        check_eq("end3_tempselx0", tempselx0, 3'b000);
        check_eq("end3_tempselx1", tempselx1, 8'h08);

        // Unmapped with stall still errors; reset aborts ERR1
        drive(T_NONSEQ, 1'b0, 32'h9000_0000, 32'h0, 1'b1, 1'b1);
        check_eq("errstall_hreadyout", hreadyout0, 1'b0);
        check_eq("errstall_valid",     valid0, 1'b0);
        tick;
        check_eq("errstall_hresp",     hresp0, 2'b01);
        check_eq("errstall_hreadyout1", hreadyout0, 1'b0);
        @(negedge Hclk);
        Hresetn  = 1'b0;
        Htrans   = T_IDLE;
        Hreadyin = 1'b0;
        stall_in = 1'b0;
        #1;
        check_eq("rsterr_hresp",     hresp0, 2'b00);
        check_eq("rsterr_hreadyout", hreadyout0, 1'b1);
        check_eq("rsterr_haddr_p",   haddr_p0, 32'h0);
        check_eq("rsterr_hwritereg", hwritereg0, 1'b0);
        check_eq("rsterr_hwdata_p",  hwdata_p0, 32'h0);
        @(negedge Hclk);
        Hresetn = 1'b1;
        tick;
        check_eq("post_rst_hresp", hresp0, 2'b00);
        check_eq("post_rst_haddr_p1", haddr_p1, 32'h0);

        // Eight regions, four-stage latency
        drive(T_NONSEQ, 1'b1, 32'h9C00_0000, 32'hCAFE_0007, 1'b1, 1'b0);
        check_eq("r7_tempselx1", tempselx1, 8'h80);
        check_eq("r7_valid1",    valid1, 1'b1);
        tick;
        check_eq("d4_lat1_haddr_p", haddr_p1, 32'h0);
        drive(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick;
        check_eq("d4_lat2_haddr_p", haddr_p1, 32'h0);
        drive(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick;
        check_eq("d4_lat3_haddr_p", haddr_p1, 32'h0);
        drive(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick;
        check_eq("d4_lat4_haddr_p",   haddr_p1, 32'h9C00_0000);
        check_eq("d4_lat4_hwritereg", hwritereg1, 1'b1);
        check_eq("d4_lat4_hwdata_p",  hwdata_p1, 32'hCAFE_0007);

        drive(T_NONSEQ, 1'b0, 32'hA000_0000, 32'h0, 1'b1, 1'b0);
        check_eq("r8_tempselx1", tempselx1, 8'h00);
        check_eq("r8_valid1",    valid1, 1'b0);
        tick;
        check_eq("r8_err1_hresp",     hresp1, 2'b01);
        check_eq("r8_err1_hreadyout", hreadyout1, 1'b0);
        drive(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        check_eq("r8_err2_hresp",     hresp1, 2'b01);
        check_eq("r8_err2_hreadyout", hreadyout1, 1'b1);
        drive(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        check_eq("r8_done_hresp", hresp1, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_itfc_gen.md
AHB_SLAVE_ITFC_GEN -- requirements
Module: ahb_slave_itfc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, address width in bits.
REQ-002 Parameter DATA_W, default 32, write-data width in bits.
REQ-003 Parameter NUM_SLAVES, default 3, number of APB slave regions; legal range 1..8.
REQ-004 Parameter BASE_ADDR, default 32'h8000_0000, start of region 0.
REQ-005 Parameter REGION_SIZE, default 32'h0400_0000, size of each region; power of two.
REQ-006 Parameter PIPE_DEPTH, default 2, address/data/write pipeline stages; legal range 1..4.
REQ-007 One clock; reset is asynchronous and active-low: Hclk and Hresetn.
REQ-008 Hclk  input  1  rising-edge clock.
REQ-009 Hresetn  input  1  asynchronous active-low reset.
REQ-010 Hwrite  input  1  AHB transfer direction, 1 = write.
REQ-011 Hreadyin  input  1  AHB bus ready.
REQ-012 Htrans  input  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-013 Haddr  input  ADDR_W  AHB address.
REQ-014 Hwdata  input  DATA_W  AHB write data.
REQ-015 stall_in  input  1  bridge backpressure; 1 inserts wait states.
REQ-016 Hreadyout  output  1  slave ready to the AHB bus.
REQ-017 Hresp  output  2  AHB response: 00 OKAY, 01 ERROR.
REQ-018 Haddr_p  output  ADDR_W  Haddr from the last pipeline stage.
REQ-019 Hwdata_p  output  DATA_W  Hwdata from the last pipeline stage.
REQ-020 Hwritereg  output  1  Hwrite from the last pipeline stage.
REQ-021 tempselx  output  NUM_SLAVES  one-hot region select, combinational.
REQ-022 valid  output  1  mapped active transfer accepted this cycle.

Function
REQ-023 mapped = BASE_ADDR <= Haddr < BASE_ADDR + NUM_SLAVES*REGION_SIZE; comparison is unsigned at ADDR_W bits.
REQ-024 When mapped, tempselx bit i SHALL be 1, where i = (Haddr-BASE_ADDR)/REGION_SIZE, with all other bits 0; when unmapped, tempselx SHALL be all 0.
REQ-025 active = Hreadyin & Htrans[1]; BUSY and IDLE transfers are never active.
REQ-026 valid SHALL be active & mapped & (state==IDLE) & ~stall_in.
REQ-027 The response FSM SHALL have three states: IDLE, ERR1 and ERR2.
REQ-028 IDLE->ERR1 when active & ~mapped; otherwise the FSM remains in IDLE.
REQ-029 ERR1->ERR2 unconditionally; ERR2->IDLE unconditionally.
REQ-030 ERR1: Hresp=01 and Hreadyout=0.
REQ-031 ERR2: Hresp=01 and Hreadyout=1.
REQ-032 IDLE: Hresp=00 and Hreadyout=~stall_in.
REQ-033 stall_in SHALL be ignored in ERR1 and ERR2; the error response always completes in exactly 2 cycles.
REQ-034 An unmapped transfer SHALL never assert valid and never advance the pipeline.
REQ-035 The pipeline is PIPE_DEPTH stages of {Haddr, Hwdata, Hwrite}; all stages shift together on a cycle where Hreadyin=1, state==IDLE and stall_in=0.
REQ-036 On any other cycle, every pipeline stage SHALL hold its value.
REQ-037 Pipeline latency from Haddr to Haddr_p is exactly PIPE_DEPTH shifting cycles; the same applies to Hwdata_p and Hwritereg.
REQ-038 Unmapped-address checking SHALL NOT apply to the pipeline; on a shift cycle every stage loads unconditionally.
REQ-039 If an active unmapped transfer and stall_in=1 occur in the same cycle, error detection takes priority: the FSM enters ERR1.
REQ-040 Address arithmetic SHALL not wrap: the region-index computation is done only when mapped.

Reset
REQ-041 Hresetn low SHALL asynchronously force state=IDLE and clear all pipeline stages, so Haddr_p=0, Hwdata_p=0 and Hwritereg=0.
REQ-042 During reset, outputs are Hresp=00 and Hreadyout=~stall_in; valid and tempselx follow their combinational definitions.
REQ-043 Reset asserted in ERR1 or ERR2 SHALL abort the error response; after release the FSM is IDLE and Hresp=00.

Verification
REQ-044 Defaults; NONSEQ write to 32'h8400_0010 with Hwdata=32'hA5A5_A5A5, Hreadyin=1, stall_in=0 -> tempselx=3'b010 and valid=1 in the same cycle; Haddr_p=32'h8400_0010 and Hwritereg=1 after 2 shift cycles; Hwdata_p=32'hA5A5_A5A5 after 2 shift cycles.
REQ-045 NONSEQ to 32'h9000_0000 -> tempselx=000 and valid=0; next cycle Hresp=01, Hreadyout=0; following cycle Hresp=01, Hreadyout=1; then Hresp=00; pipeline unchanged throughout.
REQ-046 stall_in=1 for 3 cycles during a SEQ burst to 32'h8800_0000.. -> Hreadyout=0 and valid=0 for those 3 cycles, pipeline held, resumes shifting with no lost stage.
REQ-047 Hresetn pulsed low during ERR1 -> Hresp=00 immediately, FSM IDLE, Haddr_p=0 and Hwritereg=0.
REQ-048 NUM_SLAVES=8, PIPE_DEPTH=4; address BASE_ADDR+7*REGION_SIZE -> tempselx=8'h80; address BASE_ADDR+8*REGION_SIZE -> error response; Haddr_p latency = 4.
REQ-049 BUSY transfer (Htrans=01) to an unmapped address -> Hresp=00, no error response, valid=0.
